instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage for the MIPS core: holds the PC, reads a word-addressed instruction memory with 1-cycle synchronous latency, and buffers fetched words in a 2-entry queue. It presents one instruction per cycle to the datapath with a valid/ready handshake. It accepts branch/jump redirects from downstream, flushing in-flight and queued fetches.

## Interface
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words (power of 2)
- RESET_PC, 32'h00000000, PC fetched first after reset

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- instr_ready  in  1  datapath accepts the head instruction this cycle
- redirect  in  1  taken branch/jump; overrides sequential fetch
- redirect_pc  in  32  byte address of redirect target
- imem_we  in  1  instruction memory write enable (bench/loader)
- imem_waddr  in  32  byte address for write; bits [1:0] ignored
- imem_wdata  in  32  word to write
- instruction  out  32  head-of-queue instruction
- instr_pc  out  32  byte PC of `instruction`
- pc_plus4  out  32  instr_pc + 4
- instr_valid  out  1  `instruction` is valid
- fetch_fault  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State: fetch_pc, inflight flag plus read register (word + PC tag), queue (2 entries, count 0..2), fetch_fault.
- Memory index = pc[log2(IMEM_DEPTH)+1:2]; upper bits ignored, so addresses wrap modulo IMEM_DEPTH*4.
- pop = instr_valid & instr_ready.
- Issue: when count − pop + inflight ≤ 1 and no redirect and no fault → capture mem[fetch_pc] into read register, set inflight, fetch_pc += 4 (32-bit wrap).
- Return: inflight word is pushed into the queue at the next edge unless a redirect occurs in that cycle.
- Queue: FIFO order; the head drives instruction/instr_pc/pc_plus4; instr_valid = (count != 0).
- Redirect (sampled at edge R): the head pop in cycle R still completes; the queue is cleared; inflight is discarded; fetch_pc <= redirect_pc with bits [1:0] forced to 00. No issue occurs at edge R.
- imem write: at the edge when imem_we=1. A read of the same word at the same edge returns the old data.
- Queue never overflows by construction; queue and read register contents are unchanged while stalled.

## Timing
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC, count=0, inflight=0, instr_valid=0, instruction=0, instr_pc=0, pc_plus4=4, fetch_fault=0. Memory contents are not reset.
- After rst rises: the first edge issues RESET_PC; instr_valid goes high after the second edge.
- Redirect at edge R: issue of target at R+1; target valid after R+2 (2-cycle bubble).
- Steady state with instr_ready=1: one instruction per cycle, consecutive PCs.
- Stall (instr_ready=0): at most 2 queued + 0 in flight; fetch stops.
- Resume: valid stays high continuously; the queued pair drains back-to-back.
- Simultaneous redirect and pop at the same edge: pop counts, redirect wins for all other state.
- Reset mid-operation: immediate return to reset values; in-flight data is lost.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_fault at that edge.
  - fetch_fault is sticky until reset; while set, no new issues occur.
  - The queue is already flushed by the redirect, so instr_valid stays 0.
- Undefined: fetch_fault is tied 0; low bits are silently cleared and fetch continues at the aligned address.

## Test plan
- Reset release, mem[0..3]=8C080005, 02324820, 02325022, AC09000A, instr_ready=1 → valid after 2nd edge; instr_pc 0, 4, 8, C on consecutive cycles; pc_plus4 = instr_pc+4.
- Hold instr_ready=0 for 5 cycles from instr_pc=4 → instruction stays 02324820, no PC skipped. Release → 4, 8, C back-to-back, no bubble.
- Redirect to 0x20 (mem[8]=110B0001) while the queue is full → queue flushed next edge; instr_pc=0x20, instruction 110B0001 valid exactly 2 edges later.
- Redirect and pop in the same cycle → popped instruction not repeated; next valid PC is the target.
- PC wrap: RESET_PC=IMEM_DEPTH*4−4 → fetches mem[255] then mem[0], instr_pc=0x400.
- Redirect to 0x22: with FETCH_ALIGN_CHECK_EN, fetch_fault=1 and instr_valid stays 0 until reset; without it, fetch resumes at 0x20.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : MIPS fetch stage with a 1-cycle synchronous instruction memory,
//            a 2-entry instruction queue and redirect flushing.
//            Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned
//            redirect fault).
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        imem_we,
    input  logic [31:0] imem_waddr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fetch_fault
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0] mem [IMEM_DEPTH];

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] rd_word_q,  rd_word_d;
    logic [31:0] rd_pc_q,    rd_pc_d;
    logic [31:0] q_word_q [2];
    logic [31:0] q_word_d [2];
    logic [31:0] q_pc_q   [2];
    logic [31:0] q_pc_d   [2];
    logic [1:0]  count_q,  count_d;
    logic        fault_q;
    logic        pop;
    logic        issue;
    logic [2:0]  occupancy;

    logic unused_waddr_bits;
    assign unused_waddr_bits = ^{imem_waddr[31:AW+2], imem_waddr[1:0]};

    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr[AW+1:2]] <= imem_wdata;
        end
    end

    // Occupancy after this edge's pop and return; issue only if a slot stays free.
    always_comb begin
        pop       = (count_q != 2'd0) & instr_ready;
        occupancy = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
        issue     = (occupancy <= 3'd1) & ~redirect & ~fault_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        rd_word_d  = rd_word_q;
        rd_pc_d    = rd_pc_q;
        q_word_d   = q_word_q;
        q_pc_d     = q_pc_q;
        count_d    = count_q;

        if (pop) begin
            q_word_d[0] = q_word_q[1];
            q_pc_d[0]   = q_pc_q[1];
        end

        if (redirect) begin
            count_d    = 2'd0;
            inflight_d = 1'b0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else begin
            count_d = count_q - {1'b0, pop};
            if (inflight_q) begin
                if (count_d == 2'd0) begin
                    q_word_d[0] = rd_word_q;
                    q_pc_d[0]   = rd_pc_q;
                end else begin
                    q_word_d[1] = rd_word_q;
                    q_pc_d[1]   = rd_pc_q;
                end
                count_d = count_d + 2'd1;
            end
            inflight_d = issue;
            if (issue) begin
                rd_word_d  = mem[fetch_pc_q[AW+1:2]];
                rd_pc_d    = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q  <= RESET_PC;
            inflight_q  <= 1'b0;
            rd_word_q   <= 32'd0;
            rd_pc_q     <= 32'd0;
            q_word_q[0] <= 32'd0;
            q_word_q[1] <= 32'd0;
            q_pc_q[0]   <= 32'd0;
            q_pc_q[1]   <= 32'd0;
            count_q     <= 2'd0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            inflight_q  <= inflight_d;
            rd_word_q   <= rd_word_d;
            rd_pc_q     <= rd_pc_d;
            q_word_q    <= q_word_d;
            q_pc_q      <= q_pc_d;
            count_q     <= count_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_d;
    assign fault_d = fault_q | (redirect & (redirect_pc[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign fault_q              = 1'b0;
`endif

    assign instruction = q_word_q[0];
    assign instr_pc    = q_pc_q[0];
    assign pc_plus4    = q_pc_q[0] + 32'd4;
    assign instr_valid = (count_q != 2'd0);
    assign fetch_fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench for instr_fetch_unit with a queue-based
//            reference model plus a second instance for PC wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          DEPTH   = 256;
    localparam logic [31:0] WRAP_PC = 32'(DEPTH * 4 - 4);

    logic        clk = 1'b0;
    logic        rst, rst_w;
    logic        instr_ready, redirect, imem_we;
    logic [31:0] redirect_pc, imem_waddr, imem_wdata;
    logic [31:0] instruction, instr_pc, pc_plus4;
    logic        instr_valid, fetch_fault;
    logic [31:0] w_instruction, w_instr_pc, w_pc_plus4;
    logic        w_instr_valid, w_fetch_fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .instruction(instruction), .instr_pc(instr_pc),
        .pc_plus4(pc_plus4), .instr_valid(instr_valid), .fetch_fault(fetch_fault)
    );

    instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst(rst_w), .instr_ready(1'b1), .redirect(1'b0),
        .redirect_pc(32'h0), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .instruction(w_instruction), .instr_pc(w_instr_pc),
        .pc_plus4(w_pc_plus4), .instr_valid(w_instr_valid), .fetch_fault(w_fetch_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetched words as a queue of (pc, word) pairs
    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_inf;
    bit          m_inf_v;
    bit          m_pop;
    bit          m_fault;
    logic [31:0] m_fpc;
    logic [31:0] tb_mem [DEPTH];

    task automatic m_reset();
        mq.delete();
        m_inf_v = 1'b0;
        m_fault = 1'b0;
        m_fpc   = 32'h0;
    endtask

    always @(negedge rst) m_reset();

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_pop = (mq.size() != 0) && instr_ready;
            if (m_pop) void'(mq.pop_front());
            if (redirect) begin
                mq.delete();
                m_inf_v = 1'b0;
                m_fpc   = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
                if (redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
`endif
            end else begin
                if (m_inf_v) begin
                    mq.push_back(m_inf);
                    m_inf_v = 1'b0;
                end
                if (mq.size() <= 1 && !m_fault) begin
                    m_inf.pc = m_fpc;
                    m_inf.w  = tb_mem[m_fpc[9:2]];
                    m_inf_v  = 1'b1;
                    m_fpc    = m_fpc + 32'd4;
                end
            end
        end
        if (imem_we) tb_mem[imem_waddr[9:2]] = imem_wdata;
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("instruction", instruction, mq[0].w);
                chk("instr_pc", instr_pc, mq[0].pc);
                chk("pc_plus4", pc_plus4, mq[0].pc + 32'd4);
            end
            chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instruction"}, instruction, 32'd0);
        chk({tag, "_instr_pc"}, instr_pc, 32'd0);
        chk({tag, "_pc_plus4"}, pc_plus4, 32'd4);
        chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
    endtask

    task automatic lit(input string tag, input logic [31:0] pc, input logic [31:0] w);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_pc"}, instr_pc, pc);
        chk({tag, "_instr"}, instruction, w);
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] rp;
        rst = 1'b0; rst_w = 1'b0;
        instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        imem_we = 1'b0; imem_waddr = 32'h0; imem_wdata = 32'h0;
        m_reset();
        #1;
        check_reset_values("reset");

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            case (i)
                0:       word = 32'h8C08_0005;
                1:       word = 32'h0232_4820;
                2:       word = 32'h0232_5022;
                3:       word = 32'hAC09_000A;
                8:       word = 32'h110B_0001;
                255:     word = 32'hDEAD_BEEF;
                default: word = $urandom;
            endcase
            imem_we = 1'b1; imem_waddr = i * 4; imem_wdata = word;
        end
        @(negedge clk);
        imem_we = 1'b0;
        rst = 1'b1; rst_w = 1'b1;

        @(negedge clk);
        chk("first_edge_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        lit("boot0", 32'h0, 32'h8C08_0005);
        chk("boot0_plus4", pc_plus4, 32'h4);
        chk("wrap0_pc", w_instr_pc, 32'h3FC);
        chk("wrap0_instr", w_instruction, 32'hDEAD_BEEF);
        chk("wrap0_valid", {31'd0, w_instr_valid}, 32'd1);
        @(negedge clk);
        lit("boot1", 32'h4, 32'h0232_4820);
        chk("wrap1_pc", w_instr_pc, 32'h400);
        chk("wrap1_plus4", w_pc_plus4, 32'h404);
        chk("wrap1_instr", w_instruction, 32'h8C08_0005);
        chk("wrap1_fault", {31'd0, w_fetch_fault}, 32'd0);
        instr_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            lit("stall", 32'h4, 32'h0232_4820);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        lit("resume8", 32'h8, 32'h0232_5022);
        @(negedge clk);
        lit("resumeC", 32'hC, 32'hAC09_000A);

        instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h20;
        @(negedge clk);
        redirect = 1'b0;
        chk("redir_full_r1", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        chk("redir_full_r2", {31'd0, instr_valid}, 32'd0);
        instr_ready = 1'b1;
        @(negedge clk);
        lit("redir_full_tgt", 32'h20, 32'h110B_0001);

        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0;
        @(negedge clk);
        redirect = 1'b0;
        chk("redir_pop_r1", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        chk("redir_pop_r2", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        lit("redir_pop_tgt", 32'h0, 32'h8C08_0005);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            rp = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            rp[1:0] = 2'b00;
`endif
            redirect_pc = rp;
            imem_we     = ($urandom_range(0, 7) == 0);
            imem_waddr  = $urandom;
            imem_wdata  = $urandom;
        end
        @(negedge clk);
        instr_ready = 1'b1; redirect = 1'b0; imem_we = 1'b0;
        repeat (3) @(negedge clk);

        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_values("midreset");
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        redirect = 1'b1; redirect_pc = 32'h22;
        @(negedge clk);
        redirect = 1'b0;
        repeat (2) @(negedge clk);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_fault", {31'd0, fetch_fault}, 32'd1);
        repeat (4) begin
            chk("misalign_novalid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
`else
        chk("misalign_valid", {31'd0, instr_valid}, 32'd1);
        chk("misalign_pc", instr_pc, 32'h20);
        chk("misalign_nofault", {31'd0, fetch_fault}, 32'd0);
        repeat (4) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
